// File: rtl/eta_sampler_arbiter.sv
// eta_sampler_arbiter
// Shares a single poly_uniform_eta sampler core between NREQ requesters.
// A requester's seed and nonce are latched when it wins arbitration. The core
// start/done handshake is driven from those latched values. The sampled
// polynomial is returned with a one-cycle done pulse for the winning requester.
// Optional build macro: ETA_ARB_FIXED_PRIO_EN selects fixed priority, where the
// lowest index wins. When it is undefined (the default), arbitration is round robin.
module eta_sampler_arbiter #(
    parameter int NREQ  = 2,
    parameter int SEEDW = 512,
    parameter int POLYW = 8192
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SEEDW-1:0] seed_in,
    input  logic [NREQ*16-1:0]    nonce_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done_req,
    output logic [POLYW-1:0]      poly_out,
    output logic                  busy,
    output logic                  core_start,
    output logic [SEEDW-1:0]      core_seed,
    output logic [15:0]           core_nonce,
    input  logic [POLYW-1:0]      core_a,
    input  logic                  core_done
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [PTRW-1:0]    r_rrPtr;
    logic [PTRW-1:0]    r_winIdx;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_doneReq;
    logic               r_busy;
    logic               r_coreStart;
    logic [SEEDW-1:0]   r_coreSeed;
    logic [15:0]        r_coreNonce;
    logic [POLYW-1:0]   r_poly;

    logic               w_anyReq;
    logic [PTRW-1:0]    w_winIdx;
    int                 w_scanIdx;
    logic [NREQ-1:0]    w_winOneHot;
    logic [NREQ-1:0]    w_doneOneHot;
    logic [SEEDW-1:0]   w_seedSel;
    logic [15:0]        w_nonceSel;
    logic [PTRW-1:0]    w_rrWrap;

    logic [NREQ-1:0]    w_gntNext;
    logic [NREQ-1:0]    w_doneNext;
    logic               w_busyNext;
    logic               w_startNext;
    logic [PTRW-1:0]    w_rrNext;
    logic [PTRW-1:0]    w_winNext;
    logic               w_latch;
    logic               w_polyLoad;

    // Winner selection: the first pending request, scanning upward from the rr pointer with wrap (or lowest index in fixed-priority builds)
    always_comb begin
        w_anyReq  = 1'b0;
        w_winIdx  = '0;
        w_scanIdx = 0;
`ifdef ETA_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_anyReq = 1'b1;
                w_winIdx = PTRW'(i);
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            w_scanIdx = int'(r_rrPtr) + i;
            if (w_scanIdx >= NREQ) begin
                w_scanIdx = w_scanIdx - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!w_anyReq && (j == w_scanIdx) && req[j]) begin
                    w_anyReq = 1'b1;
                    w_winIdx = PTRW'(j);
                end
            end
        end
`endif
    end

    // Input muxing for the candidate winner and one-hot decode of the granted index
    always_comb begin
        w_seedSel    = '0;
        w_nonceSel   = '0;
        w_winOneHot  = '0;
        w_doneOneHot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winIdx == PTRW'(i)) begin
                w_seedSel      = seed_in[SEEDW*i +: SEEDW];
                w_nonceSel     = nonce_in[16*i +: 16];
                w_winOneHot[i] = 1'b1;
            end
            if (r_winIdx == PTRW'(i)) begin
                w_doneOneHot[i] = 1'b1;
            end
        end
    end

    // Pointer advance past the last winner; the wrap is explicit so non-power-of-2 NREQ works
    always_comb begin
        if (r_winIdx == PTRW'(NREQ - 1)) begin
            w_rrWrap = '0;
        end else begin
            w_rrWrap = r_winIdx + PTRW'(1);
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_stateNext = r_state;
        w_gntNext   = '0;
        w_doneNext  = '0;
        w_busyNext  = 1'b0;
        w_startNext = 1'b0;
        w_rrNext    = r_rrPtr;
        w_winNext   = r_winIdx;
        w_latch     = 1'b0;
        w_polyLoad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_stateNext = ST_ISSUE;
                    w_gntNext   = w_winOneHot;
                    w_winNext   = w_winIdx;
                    w_latch     = 1'b1;
                    w_busyNext  = 1'b1;
                    w_startNext = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_stateNext = ST_WAIT;
                w_busyNext  = 1'b1;
                w_startNext = 1'b1;
            end
            ST_WAIT: begin
                w_busyNext = 1'b1;
                if (core_done) begin
                    w_stateNext = ST_RESP;
                    w_polyLoad  = 1'b1;
                    w_doneNext  = w_doneOneHot;
                    w_startNext = 1'b0;
                end else begin
                    w_startNext = 1'b1;
                end
            end
            ST_RESP: begin
                w_stateNext = ST_IDLE;
`ifdef ETA_ARB_FIXED_PRIO_EN
                w_rrNext    = '0;
`else
                w_rrNext    = w_rrWrap;
`endif
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Handshake outputs and arbitration bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt       <= '0;
            r_doneReq   <= '0;
            r_busy      <= 1'b0;
            r_coreStart <= 1'b0;
            r_rrPtr     <= '0;
            r_winIdx    <= '0;
        end else begin
            r_gnt       <= w_gntNext;
            r_doneReq   <= w_doneNext;
            r_busy      <= w_busyNext;
            r_coreStart <= w_startNext;
            r_rrPtr     <= w_rrNext;
            r_winIdx    <= w_winNext;
        end
    end

    // Seed and nonce are captured only at grant, so later input changes cannot disturb a running job
    always_ff @(posedge clock) begin
        if (reset) begin
            r_coreSeed  <= '0;
            r_coreNonce <= '0;
        end else if (w_latch) begin
            r_coreSeed  <= w_seedSel;
            r_coreNonce <= w_nonceSel;
        end
    end

    // Result capture on core completion; the value holds until the next job completes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_poly <= '0;
        end else if (w_polyLoad) begin
            r_poly <= core_a;
        end
    end

    assign gnt        = r_gnt;
    assign done_req   = r_doneReq;
    assign busy       = r_busy;
    assign core_start = r_coreStart;
    assign core_seed  = r_coreSeed;
    assign core_nonce = r_coreNonce;
    assign poly_out   = r_poly;

endmodule

// File: tb/tb_eta_sampler_arbiter.sv
// tb_eta_sampler_arbiter
// Table-driven bench for eta_sampler_arbiter, followed by hand-written
// sequences for hold-off, mid-job reset and spurious core_done.
// Honours ETA_ARB_FIXED_PRIO_EN for the expected grant order.
`timescale 1ns/1ps
module tb_eta_sampler_arbiter;

    localparam int NREQ  = 2;
    localparam int SEEDW = 512;
    localparam int POLYW = 8192;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*SEEDW-1:0] seed_in;
    logic [NREQ*16-1:0]    nonce_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done_req;
    logic [POLYW-1:0]      poly_out;
    logic                  busy;
    logic                  core_start;
    logic [SEEDW-1:0]      core_seed;
    logic [15:0]           core_nonce;
    logic [POLYW-1:0]      core_a;
    logic                  core_done;

    always #5 clock = ~clock;

    eta_sampler_arbiter #(
        .NREQ  (NREQ),
        .SEEDW (SEEDW),
        .POLYW (POLYW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .seed_in    (seed_in),
        .nonce_in   (nonce_in),
        .gnt        (gnt),
        .done_req   (done_req),
        .poly_out   (poly_out),
        .busy       (busy),
        .core_start (core_start),
        .core_seed  (core_seed),
        .core_nonce (core_nonce),
        .core_a     (core_a),
        .core_done  (core_done)
    );

    typedef struct {
        bit          doReset;
        logic [1:0]  req;
        logic [15:0] nonce0;
        logic [15:0] nonce1;
        int          doneDelay;
        logic [1:0]  expGnt;
        logic [15:0] expNonce;
        logic [1:0]  dropAfter;
        bit          chkGap;
    } vec_t;

    vec_t             vecs[8];
    int               vecCount  = 0;
    int               missCount = 0;
    int               gapCount  = 0;
    int               jobId     = 0;
    logic [SEEDW-1:0] seed0;
    logic [SEEDW-1:0] seed1;
    logic [POLYW-1:0] lastPoly;

    // Narrow comparison
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wide comparison over the full width, reporting only the low 64 bits
    task automatic checkWide(input string name, input logic [POLYW-1:0] act, input logic [POLYW-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got low64 %0h, expected low64 %0h", name, act[63:0], exp[63:0]);
        end
    endtask

    // Synchronous reset for two cycles; returns on a falling edge with reset released
    task automatic doReset();
        reset     = 1'b1;
        req       = '0;
        core_done = 1'b0;
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        lastPoly = '0;
        gapCount = 0;
    endtask

    // Wait a bounded number of cycles for a grant, counting core_start-low cycles seen on the way
    task automatic waitGnt(output bit ok, output int lowCount);
        ok       = 1'b0;
        lowCount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
            if (!core_start) lowCount++;
        end
    endtask

    // One complete job: request, grant, delayed core ack, done pulse, return to idle
    task automatic applyStimulus(input vec_t v);
        bit               ok;
        int               low;
        bit               startHeld;
        logic [31:0]      word;
        logic [POLYW-1:0] pattern;
        if (v.doReset) doReset();
        req      = v.req;
        nonce_in = {v.nonce1, v.nonce0};
        waitGnt(ok, low);
        checkOutput("gnt_seen", {63'd0, ok}, 64'd1);
        if (ok) begin
            checkOutput("gnt", {62'd0, gnt}, {62'd0, v.expGnt});
            checkOutput("core_nonce", {48'd0, core_nonce}, {48'd0, v.expNonce});
            checkWide("core_seed", {{(POLYW-SEEDW){1'b0}}, core_seed},
                      {{(POLYW-SEEDW){1'b0}}, (v.expGnt[0] ? seed0 : seed1)});
            checkOutput("issue_start", {63'd0, core_start}, 64'd1);
            checkOutput("issue_busy", {63'd0, busy}, 64'd1);
            if (v.chkGap) checkOutput("start_gap_ge2", {63'd0, (gapCount + low) >= 2}, 64'd1);
            word    = 32'hC0DE0000 + 32'(jobId);
            jobId++;
            pattern = {256{word}};
            core_a  = pattern;
            startHeld = 1'b1;
            for (int d = 0; d < v.doneDelay; d++) begin
                @(negedge clock);
                if (d == 0) checkOutput("gnt_pulse", {62'd0, gnt}, 64'd0);
                if (!core_start || (done_req != '0)) startHeld = 1'b0;
            end
            checkOutput("start_held", {63'd0, startHeld}, 64'd1);
            core_done = 1'b1;
            @(negedge clock);
            core_done = 1'b0;
            checkOutput("done_req", {62'd0, done_req}, {62'd0, v.expGnt});
            checkWide("poly_out", poly_out, pattern);
            checkOutput("resp_start", {63'd0, core_start}, 64'd0);
            lastPoly = pattern;
            gapCount = core_start ? 0 : 1;
            req      = req & ~v.dropAfter;
            @(negedge clock);
            checkOutput("done_pulse", {62'd0, done_req}, 64'd0);
            checkOutput("idle_busy", {63'd0, busy}, 64'd0);
            if (!core_start) gapCount++;
        end
    endtask

    initial begin
        bit   ok;
        int   low;
        vec_t extra;

        reset     = 1'b1;
        req       = '0;
        core_done = 1'b0;
        core_a    = '0;
        nonce_in  = '0;
        seed0     = {16{32'h5EED0000}};
        seed1     = {16{32'h5EED0001}};
        seed_in   = {seed1, seed0};
        lastPoly  = '0;

        // Fill the vector table
        vecs[0] = '{1'b1, 2'b01, 16'h0003, 16'h0009, 2,  2'b01, 16'h0003, 2'b01, 1'b0};
        vecs[1] = '{1'b1, 2'b11, 16'h0000, 16'h0005, 10, 2'b01, 16'h0000, 2'b00, 1'b0};
`ifdef ETA_ARB_FIXED_PRIO_EN
        vecs[2] = '{1'b0, 2'b11, 16'h0000, 16'h0005, 10, 2'b01, 16'h0000, 2'b00, 1'b1};
        vecs[3] = '{1'b0, 2'b11, 16'h0000, 16'h0005, 10, 2'b01, 16'h0000, 2'b11, 1'b1};
        vecs[4] = '{1'b0, 2'b10, 16'h0000, 16'h1234, 3,  2'b10, 16'h1234, 2'b10, 1'b0};
        vecs[5] = '{1'b0, 2'b11, 16'h00BB, 16'h1234, 1,  2'b01, 16'h00BB, 2'b01, 1'b0};
        vecs[6] = '{1'b0, 2'b10, 16'h00BB, 16'h1234, 1,  2'b10, 16'h1234, 2'b10, 1'b1};
        vecs[7] = '{1'b0, 2'b11, 16'h00CC, 16'h4321, 2,  2'b01, 16'h00CC, 2'b11, 1'b0};
`else
        vecs[2] = '{1'b0, 2'b11, 16'h0000, 16'h0005, 10, 2'b10, 16'h0005, 2'b00, 1'b1};
        vecs[3] = '{1'b0, 2'b11, 16'h0000, 16'h0005, 10, 2'b01, 16'h0000, 2'b00, 1'b1};
        vecs[4] = '{1'b0, 2'b11, 16'h0000, 16'h0005, 10, 2'b10, 16'h0005, 2'b11, 1'b1};
        vecs[5] = '{1'b0, 2'b10, 16'h0000, 16'h1234, 3,  2'b10, 16'h1234, 2'b10, 1'b0};
        vecs[6] = '{1'b0, 2'b11, 16'h00BB, 16'h1234, 1,  2'b01, 16'h00BB, 2'b01, 1'b0};
        vecs[7] = '{1'b0, 2'b10, 16'h00BB, 16'h1234, 1,  2'b10, 16'h1234, 2'b10, 1'b1};
`endif

        // Reset state
        @(negedge clock);
        doReset();
        checkOutput("rst_gnt", {62'd0, gnt}, 64'd0);
        checkOutput("rst_done", {62'd0, done_req}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_start", {63'd0, core_start}, 64'd0);
        checkOutput("rst_nonce", {48'd0, core_nonce}, 64'd0);
        checkWide("rst_seed", {{(POLYW-SEEDW){1'b0}}, core_seed}, '0);
        checkWide("rst_poly", poly_out, '0);

        // Table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Hold-off: seed/nonce changed and request dropped after grant
        doReset();
        req      = 2'b01;
        nonce_in = {16'h0000, 16'h00AA};
        seed_in  = {seed1, seed0};
        waitGnt(ok, low);
        checkOutput("holdoff_gnt_seen", {63'd0, ok}, 64'd1);
        @(negedge clock);
        @(negedge clock);
        seed_in[SEEDW-1:0] = 512'h1;
        nonce_in[15:0]     = 16'hFFFF;
        req                = '0;
        repeat (3) @(negedge clock);
        checkWide("holdoff_seed_wait", {{(POLYW-SEEDW){1'b0}}, core_seed}, {{(POLYW-SEEDW){1'b0}}, seed0});
        core_a    = {256{32'hFACE0001}};
        core_done = 1'b1;
        @(negedge clock);
        core_done = 1'b0;
        checkOutput("holdoff_done", {62'd0, done_req}, 64'd1);
        checkWide("holdoff_seed_done", {{(POLYW-SEEDW){1'b0}}, core_seed}, {{(POLYW-SEEDW){1'b0}}, seed0});
        checkOutput("holdoff_nonce", {48'd0, core_nonce}, 64'h00AA);
        checkWide("holdoff_poly", poly_out, {256{32'hFACE0001}});
        @(negedge clock);
        seed_in = {seed1, seed0};

        // Reset mid-job while waiting on the core
        doReset();
        req      = 2'b01;
        nonce_in = {16'h0000, 16'h0003};
        waitGnt(ok, low);
        checkOutput("midrst_gnt_seen", {63'd0, ok}, 64'd1);
        repeat (3) @(negedge clock);
        checkOutput("midrst_start_before", {63'd0, core_start}, 64'd1);
        reset = 1'b1;
        req   = '0;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midrst_start", {63'd0, core_start}, 64'd0);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_done", {62'd0, done_req}, 64'd0);
        lastPoly = '0;

        // Spurious core_done while idle
        core_a    = {256{32'hBAD0BAD0}};
        core_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("spur_done", {62'd0, done_req}, 64'd0);
            checkOutput("spur_busy", {63'd0, busy}, 64'd0);
        end
        core_done = 1'b0;
        checkWide("spur_poly", poly_out, lastPoly);

        // The next request after the abort runs normally
        extra = '{1'b0, 2'b01, 16'h0042, 16'h0077, 2, 2'b01, 16'h0042, 2'b01, 1'b0};
        applyStimulus(extra);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
